// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
package memory_arbiter_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } requester_t;

    typedef struct packed {
        logic       valid;
        requester_t owner;
    } read_tag_t;

    localparam read_tag_t TAG_IDLE = '{valid: 1'b0, owner: REQ_A};

endpackage : memory_arbiter_pkg

// File: rtl/peripheral_memory_interface.sv
// Connection bundle between the arbiter and the single-port RAM.
interface peripheral_memory_interface #(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned ADDRESSWIDTH = 8
);
    logic                    clk;
    logic                    reset;
    logic                    read_en;
    logic                    write_en;
    logic [ADDRESSWIDTH-1:0] address;
    logic [DATAWIDTH-1:0]    data_in;
    logic [DATAWIDTH-1:0]    data_out;

    modport out (
        output clk, reset, read_en, write_en, address, data_in,
        input  data_out
    );

    modport ram (
        input  clk, reset, read_en, write_en, address, data_in,
        output data_out
    );
endinterface : peripheral_memory_interface

// File: rtl/read_tag_pipeline.sv
// Delay line carrying {valid, owner} of each accepted read until its RAM data returns.
module read_tag_pipeline
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  read_tag_t tag_i,
    output read_tag_t tag_o
);

    read_tag_t tag_q [LATENCY];
    read_tag_t tag_d [LATENCY];

    // Next stage contents: new tag enters stage 0, others shift by one.
    always_comb begin
        tag_d[0] = tag_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i] <= TAG_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_o = tag_q[LATENCY-1];

endmodule : read_tag_pipeline

// File: rtl/memory_port_arbiter.sv
// Round-robin sharing of one single-port RAM between requesters A and B,
// with read-after-write stalling and tagged read-data return.
module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned DATADEPTH     = 256,
    parameter int unsigned LATENCY       = 1,
    parameter int unsigned ADDRESSWIDTH  = $clog2(DATADEPTH),
    parameter int unsigned HAZARD_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_read,
    input  logic                    a_write,
    input  logic [ADDRESSWIDTH-1:0] a_address,
    input  logic [31:0]             a_data_in,
    output logic                    a_ready,
    output logic                    a_read_valid,
    output logic [31:0]             a_data_out,
    input  logic                    b_read,
    input  logic                    b_write,
    input  logic [ADDRESSWIDTH-1:0] b_address,
    input  logic [31:0]             b_data_in,
    output logic                    b_ready,
    output logic                    b_read_valid,
    output logic [31:0]             b_data_out,
    peripheral_memory_interface.out mem_io
);

    requester_t              last_grant_q, last_grant_d;
    logic                    hist_valid_q [HAZARD_CYCLES];
    logic                    hist_valid_d [HAZARD_CYCLES];
    logic [ADDRESSWIDTH-1:0] hist_addr_q  [HAZARD_CYCLES];
    logic [ADDRESSWIDTH-1:0] hist_addr_d  [HAZARD_CYCLES];

    logic      a_hazard, b_hazard;
    logic      a_elig, b_elig;
    logic      a_grant, b_grant;
    logic      rd_en, wr_en;
    read_tag_t tag_in, tag_out;

    // Reads to an address written within the stale-data window must wait.
    always_comb begin
        a_hazard = 1'b0;
        b_hazard = 1'b0;
        for (int unsigned i = 0; i < HAZARD_CYCLES; i++) begin
            if (hist_valid_q[i] && hist_addr_q[i] == a_address) a_hazard = 1'b1;
            if (hist_valid_q[i] && hist_addr_q[i] == b_address) b_hazard = 1'b1;
        end
    end

    assign a_elig = a_write || (a_read && !a_hazard);
    assign b_elig = b_write || (b_read && !b_hazard);

    // Under contention the requester that was not served last wins.
    assign a_grant = a_elig && (!b_elig || last_grant_q == REQ_B);
    assign b_grant = b_elig && (!a_elig || last_grant_q == REQ_A);

    assign a_ready = reset_n && a_grant;
    assign b_ready = reset_n && b_grant;

    // A request with both strobes set is executed as a write only.
    assign wr_en = (a_ready && a_write) || (b_ready && b_write);
    assign rd_en = (a_ready && a_read && !a_write) || (b_ready && b_read && !b_write);

    assign mem_io.clk      = clk;
    assign mem_io.reset    = !reset_n;
    assign mem_io.read_en  = rd_en;
    assign mem_io.write_en = wr_en;
    assign mem_io.address  = b_ready ? b_address : a_address;
    assign mem_io.data_in  = DATAWIDTH'(b_ready ? b_data_in : a_data_in);

    // Next arbitration pointer and write-history contents.
    always_comb begin
        last_grant_d = last_grant_q;
        if (a_ready) begin
            last_grant_d = REQ_A;
        end else if (b_ready) begin
            last_grant_d = REQ_B;
        end
        hist_valid_d[0] = wr_en;
        hist_addr_d[0]  = mem_io.address;
        for (int unsigned i = 1; i < HAZARD_CYCLES; i++) begin
            hist_valid_d[i] = hist_valid_q[i-1];
            hist_addr_d[i]  = hist_addr_q[i-1];
        end
    end

    // Arbitration pointer and write-history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= REQ_B;
            for (int unsigned i = 0; i < HAZARD_CYCLES; i++) begin
                hist_valid_q[i] <= 1'b0;
                hist_addr_q[i]  <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            for (int unsigned i = 0; i < HAZARD_CYCLES; i++) begin
                hist_valid_q[i] <= hist_valid_d[i];
                hist_addr_q[i]  <= hist_addr_d[i];
            end
        end
    end

    assign tag_in = '{valid: rd_en, owner: (b_ready ? REQ_B : REQ_A)};

    read_tag_pipeline #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (reset_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Steer returning RAM data to the owner of the matching read.
    assign a_read_valid = tag_out.valid && tag_out.owner == REQ_A;
    assign b_read_valid = tag_out.valid && tag_out.owner == REQ_B;
    assign a_data_out   = a_read_valid ? 32'(mem_io.data_out) : 32'h0;
    assign b_data_out   = b_read_valid ? 32'(mem_io.data_out) : 32'h0;

endmodule : memory_port_arbiter

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_memory_port_arbiter;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_read, a_write, b_read, b_write;
    logic [AW-1:0] a_address, b_address;
    logic [31:0]   a_data_in, b_data_in;
    logic          a_ready, a_read_valid, b_ready, b_read_valid;
    logic [31:0]   a_data_out, b_data_out;

    int n_checks = 0;
    int n_errors = 0;

    peripheral_memory_interface #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) mem_if ();

    memory_port_arbiter #(
        .DATAWIDTH(DW), .DATADEPTH(256), .LATENCY(LAT), .ADDRESSWIDTH(AW), .HAZARD_CYCLES(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_data_in(a_data_in),
        .a_ready(a_ready), .a_read_valid(a_read_valid), .a_data_out(a_data_out),
        .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_data_in(b_data_in),
        .b_ready(b_ready), .b_read_valid(b_read_valid), .b_data_out(b_data_out),
        .mem_io(mem_if)
    );

    always #5 clk = ~clk;

    // RAM model: 2-cycle read latency, writes land one cycle late (stale window).
    logic [DW-1:0] ram [256] = '{default: 16'h0};
    logic          pend_v = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    logic [DW-1:0] rd1 = '0, rd2 = '0;
    always @(posedge clk) begin
        if (pend_v) ram[pend_a] <= pend_d;
        pend_v <= mem_if.write_en;
        pend_a <= mem_if.address;
        pend_d <= mem_if.data_in;
        if (mem_if.read_en) rd1 <= ram[mem_if.address];
        rd2 <= rd1;
    end
    assign mem_if.data_out = rd2;

    task automatic idle();
        a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        a_read = 1; a_write = 0; b_read = 0; b_write = 1;
        a_address = 8'h01; b_address = 8'h02; a_data_in = 0; b_data_in = 0;
        @(negedge clk); #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready}); end
        n_checks++; if ({mem_if.read_en, mem_if.write_en} !== 2'b00) begin n_errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_if.read_en, mem_if.write_en}); end
        n_checks++; if ({a_read_valid, b_read_valid} !== 2'b00 || a_data_out !== 0 || b_data_out !== 0) begin n_errors++; $display("FAIL reset_outputs: valid %b data %h %h want 0", {a_read_valid, b_read_valid}, a_data_out, b_data_out); end
        idle();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_single_read();
        @(negedge clk); a_write = 1; a_address = 8'h05; a_data_in = 32'h1234; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t1_preload_ready: got %b want 1", a_ready); end
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); a_read = 1; a_address = 8'h05; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t1_read_ready: got %b want 1", a_ready); end
        @(negedge clk); idle(); #1;
        n_checks++; if (a_read_valid !== 1'b0) begin n_errors++; $display("FAIL t1_early_valid: got %b want 0", a_read_valid); end
        @(negedge clk); #1;
        n_checks++; if (a_read_valid !== 1'b1 || a_data_out !== 32'h0000_1234) begin n_errors++; $display("FAIL t1_read_data: valid %b data %h want 1 00001234", a_read_valid, a_data_out); end
        n_checks++; if (b_read_valid !== 1'b0 || b_data_out !== 0) begin n_errors++; $display("FAIL t1_b_quiet: valid %b data %h want 0 0", b_read_valid, b_data_out); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic exp_a;
        @(negedge clk); a_write = 1; a_address = 8'h01; a_data_in = 32'h1111;
        @(negedge clk); a_address = 8'h02; a_data_in = 32'h2222;
        @(negedge clk); idle();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a_read = 1; a_address = 8'h01; b_read = 1; b_address = 8'h02; #1;
            exp_a = (k % 2 == 0);
            n_checks++; if (a_ready !== exp_a || b_ready !== !exp_a) begin n_errors++; $display("FAIL t2_grant[%0d]: a/b ready %b%b want %b%b", k, a_ready, b_ready, exp_a, !exp_a); end
            if (k >= 2) begin
                exp_a = ((k - 2) % 2 == 0);
                n_checks++;
                if (a_read_valid !== exp_a || b_read_valid !== !exp_a ||
                    a_data_out !== (exp_a ? 32'h1111 : 32'h0) || b_data_out !== (exp_a ? 32'h0 : 32'h2222)) begin
                    n_errors++;
                    $display("FAIL t2_return[%0d]: valid %b%b data %h %h", k, a_read_valid, b_read_valid, a_data_out, b_data_out);
                end
            end
        end
        idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hazard();
        @(negedge clk); a_write = 1; a_address = 8'h10; a_data_in = 32'hBEEF; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t3_write_ready: got %b want 1", a_ready); end
        @(negedge clk); idle(); b_read = 1; b_address = 8'h10; #1;
        n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL t3_stall: got %b want 0", b_ready); end
        @(negedge clk); #1;
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL t3_release: got %b want 1", b_ready); end
        @(negedge clk); idle();
        @(negedge clk); #1;
        n_checks++; if (b_read_valid !== 1'b1 || b_data_out !== 32'h0000_BEEF || a_read_valid !== 1'b0) begin n_errors++; $display("FAIL t3_data: valid %b data %h want 1 0000beef", b_read_valid, b_data_out); end
        @(negedge clk); a_write = 1; a_address = 8'h10; a_data_in = 32'h5555;
        @(negedge clk); idle(); b_read = 1; b_address = 8'h11; #1;
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL t3_other_addr: got %b want 1", b_ready); end
        @(negedge clk); idle();
        @(negedge clk); #1;
        n_checks++; if (b_read_valid !== 1'b1 || b_data_out !== 32'h0) begin n_errors++; $display("FAIL t3_other_data: valid %b data %h want 1 0", b_read_valid, b_data_out); end
        @(negedge clk);
    endtask

    task automatic test_write_vs_read();
        @(negedge clk); a_read = 1; a_address = 8'h00; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t4_setup: got %b want 1", a_ready); end
        @(negedge clk); a_read = 0; a_write = 1; a_address = 8'h20; a_data_in = 32'h0000_FFFF;
        b_read = 1; b_address = 8'h21; #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b01) begin n_errors++; $display("FAIL t4_first_grant: a/b %b want 01", {a_ready, b_ready}); end
        n_checks++; if ({mem_if.read_en, mem_if.write_en} !== 2'b10 || mem_if.address !== 8'h21) begin n_errors++; $display("FAIL t4_first_op: rd/wr %b addr %h want 10 21", {mem_if.read_en, mem_if.write_en}, mem_if.address); end
        @(negedge clk); b_read = 0; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t4_second_grant: got %b want 1", a_ready); end
        n_checks++; if ({mem_if.read_en, mem_if.write_en} !== 2'b01 || mem_if.address !== 8'h20 || mem_if.data_in !== 16'hFFFF) begin n_errors++; $display("FAIL t4_second_op: rd/wr %b addr %h data %h", {mem_if.read_en, mem_if.write_en}, mem_if.address, mem_if.data_in); end
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); a_read = 1; a_address = 8'h30; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t5_accept: got %b want 1", a_ready); end
        @(negedge clk); reset_n = 0; a_read = 1; b_write = 1; b_address = 8'h31; #1;
        n_checks++; if ({a_ready, b_ready, mem_if.read_en, mem_if.write_en} !== 4'b0000) begin n_errors++; $display("FAIL t5_in_reset: ready %b%b en %b%b want 0000", a_ready, b_ready, mem_if.read_en, mem_if.write_en); end
        @(negedge clk); #1;
        n_checks++; if ({a_read_valid, b_read_valid} !== 2'b00 || a_data_out !== 0) begin n_errors++; $display("FAIL t5_flushed: valid %b%b data %h want 0", a_read_valid, b_read_valid, a_data_out); end
        reset_n = 1; idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++; if ({a_read_valid, b_read_valid} !== 2'b00) begin n_errors++; $display("FAIL t5_ghost[%0d]: valid %b%b want 00", k, a_read_valid, b_read_valid); end
        end
        @(negedge clk); a_read = 1; a_address = 8'h31; b_read = 1; b_address = 8'h32; #1;
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_errors++; $display("FAIL t5_first_grant: a/b %b want 10", {a_ready, b_ready}); end
        @(negedge clk); idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_truncation();
        @(negedge clk); a_write = 1; a_address = 8'h40; a_data_in = 32'hFFFF_ABCD; #1;
        n_checks++; if (a_ready !== 1'b1 || mem_if.data_in !== 16'hABCD) begin n_errors++; $display("FAIL t6_trunc: ready %b data_in %h want 1 abcd", a_ready, mem_if.data_in); end
        @(negedge clk); idle();
        @(negedge clk); a_read = 1; a_address = 8'h40; #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL t6_read_ready: got %b want 1", a_ready); end
        @(negedge clk); idle();
        @(negedge clk); #1;
        n_checks++; if (a_read_valid !== 1'b1 || a_data_out !== 32'h0000_ABCD) begin n_errors++; $display("FAIL t6_read_data: valid %b data %h want 1 0000abcd", a_read_valid, a_data_out); end
        @(negedge clk);
    endtask

    typedef struct {
        int          due;
        bit          owner;   // 0 = A, 1 = B
        logic [31:0] data;
    } ret_t;

    task automatic test_random();
        ret_t          ret_q[$];
        ret_t          e;
        logic [DW-1:0] ref_mem [256];
        bit            pa_v = 0, pb_v = 0, pa_rd, pa_wr, pb_rd, pb_wr;
        logic [AW-1:0] pa_ad, pb_ad;
        logic [31:0]   pa_d, pb_d;
        bit            lg = 1;        // last served: B after reset
        bit            prev_w = 0;    // a write happened last cycle
        logic [AW-1:0] prev_a = '0;
        bit            ea, eb, ga, gb, exp_av, exp_bv;
        logic [31:0]   exp_d;
        int            r;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!pa_v && cyc < 396) begin
                r = int'($urandom_range(0, 5));
                pa_v = (r >= 2); pa_rd = (r == 2 || r == 3 || r == 5); pa_wr = (r >= 4);
                pa_ad = AW'(8'h80 + $urandom_range(0, 3)); pa_d = $urandom;
            end
            if (!pb_v && cyc < 396) begin
                r = int'($urandom_range(0, 5));
                pb_v = (r >= 2); pb_rd = (r == 2 || r == 3 || r == 5); pb_wr = (r >= 4);
                pb_ad = AW'(8'h80 + $urandom_range(0, 3)); pb_d = $urandom;
            end
            a_read = pa_v && pa_rd; a_write = pa_v && pa_wr; a_address = pa_ad; a_data_in = pa_d;
            b_read = pb_v && pb_rd; b_write = pb_v && pb_wr; b_address = pb_ad; b_data_in = pb_d;
            #1;
            ea = pa_v && (pa_wr || !(prev_w && prev_a == pa_ad));
            eb = pb_v && (pb_wr || !(prev_w && prev_a == pb_ad));
            ga = ea && (!eb || lg == 1);
            gb = eb && (!ea || lg == 0);
            n_checks++; if (a_ready !== ga || b_ready !== gb) begin n_errors++; $display("FAIL rnd_grant[%0d]: a/b ready %b%b want %b%b", cyc, a_ready, b_ready, ga, gb); end
            exp_av = 0; exp_bv = 0; exp_d = 0;
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                e = ret_q.pop_front();
                exp_d = e.data;
                if (e.owner) exp_bv = 1; else exp_av = 1;
            end
            n_checks++;
            if (a_read_valid !== exp_av || b_read_valid !== exp_bv ||
                a_data_out !== (exp_av ? exp_d : 32'h0) || b_data_out !== (exp_bv ? exp_d : 32'h0)) begin
                n_errors++;
                $display("FAIL rnd_return[%0d]: valid %b%b data %h %h want %b%b %h", cyc, a_read_valid, b_read_valid, a_data_out, b_data_out, exp_av, exp_bv, exp_d);
            end
            prev_w = 0;
            if (ga) begin
                if (pa_wr) begin ref_mem[pa_ad] = pa_d[DW-1:0]; prev_w = 1; prev_a = pa_ad; end
                else ret_q.push_back('{due: cyc + int'(LAT), owner: 1'b0, data: 32'(ref_mem[pa_ad])});
                lg = 0; pa_v = 0;
            end
            if (gb) begin
                if (pb_wr) begin ref_mem[pb_ad] = pb_d[DW-1:0]; prev_w = 1; prev_a = pb_ad; end
                else ret_q.push_back('{due: cyc + int'(LAT), owner: 1'b1, data: 32'(ref_mem[pb_ad])});
                lg = 1; pb_v = 0;
            end
        end
        idle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        idle();
        a_address = '0; b_address = '0; a_data_in = '0; b_data_in = '0;
        reset_n = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_hazard();
        test_write_vs_read();
        test_reset_midflight();
        test_truncation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_memory_port_arbiter
